lfsr_seq_ctrl: RTL and testbench

- Sequencer for the 8-bit LFSR datapath in the tt_um_sahrdayalfsr design.
- On each start command it loads a seed into the LFSR and steps it a programmed number of times.
- Each LFSR state is presented on a valid/ready output stream.
- It guards against the all-zero lockup seed and signals completion with a one-cycle pulse.

---
 rtl/lfsr_seq_ctrl_if.sv | 20 ++
 rtl/lfsr_seq_ctrl.sv | 97 +++++++++
 tb/tb_lfsr_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_seq_ctrl_if.sv
// rtl/lfsr_seq_ctrl_if.sv - sample stream bundle between the LFSR sequencer and its consumer
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - seeds and steps an external LFSR, streaming each state as a sample
module lfsr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [WIDTH-1:0]  seed,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              lfsr_load,
  output logic [WIDTH-1:0]  lfsr_seed,
  output logic              lfsr_step,
  input  logic [WIDTH-1:0]  lfsr_q,
  lfsr_seq_ctrl_if.master   smp,
  output logic              busy,
  output logic              done,
  output logic              err_lockup
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    EMIT,
    STEP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      lfsr_seed  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_lockup <= 1'b0;
    end else if (ena) begin
      // abort wins over everything, including a handshake in the same cycle
      if (abort && state != IDLE) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        rem     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (count == '0) begin
                state <= DONE;
              end else if (seed == '0) begin
                err_lockup <= 1'b1;
                state      <= DONE;
              end else begin
                rem        <= count;
                lfsr_seed  <= seed;
                err_lockup <= 1'b0;
                state      <= LOAD;
              end
            end
          end
          LOAD:    state <= CAPTURE;
          CAPTURE: begin
            data_q  <= lfsr_q;
            valid_q <= 1'b1;
            state   <= EMIT;
          end
          EMIT: begin
            if (valid_q && smp.out_ready) begin
              valid_q <= 1'b0;
              rem     <= rem - CNT_W'(1);
              state   <= (rem == CNT_W'(1)) ? DONE : STEP;
            end
          end
          STEP:    state <= CAPTURE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // strobes are gated by ena so a frozen cycle neither loses nor repeats them
  assign lfsr_load     = ena && (state == LOAD);
  assign lfsr_step     = ena && (state == STEP);
  assign done          = ena && (state == DONE);
  assign busy          = (state != IDLE);
  assign smp.out_valid = valid_q && ena;
  assign smp.out_data  = data_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - directed bench for lfsr_seq_ctrl with a sample scoreboard
module tb_lfsr_seq_ctrl;
  localparam int W = 8;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] seed = '0;
  logic [C-1:0] count = '0;
  logic         lfsr_load, lfsr_step, busy, done, err_lockup;
  logic [W-1:0] lfsr_seed;
  logic [W-1:0] lfsr_q;

  lfsr_seq_ctrl_if #(.WIDTH(W)) smp_if ();

  lfsr_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .seed       (seed),
    .count      (count),
    .abort      (abort),
    .lfsr_load  (lfsr_load),
    .lfsr_seed  (lfsr_seed),
    .lfsr_step  (lfsr_step),
    .lfsr_q     (lfsr_q),
    .smp        (smp_if),
    .busy       (busy),
    .done       (done),
    .err_lockup (err_lockup)
  );

  always #5 clk = ~clk;

  // x^8+x^6+x^5+x^4+1, shifting left
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lfsr_q <= '0;
    else if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q);
  end

  int n_chk = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int base = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int got[$], input int want[$]);
    chk({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk(name, got[i], want[i]);
  endtask

  int         load_q[$], step_q[$], hs_q[$], done_q[$];
  logic [7:0] hsd_q[$], exp_q[$];
  int         busy_n = 0;
  logic       pv_valid = 0, pv_ready = 0, pv_abort = 0;
  logic [7:0] pv_data = '0;

  always @(negedge clk) begin
    int rel;
    rel = edge_cnt - base;
    if (!rst_n) begin
      pv_valid = 1'b0;
    end else begin
      if (lfsr_load) load_q.push_back(rel);
      if (lfsr_step) step_q.push_back(rel);
      if (done)      done_q.push_back(rel);
      if (busy)      busy_n++;
      if (!busy) chk("idle_quiet", {lfsr_load, lfsr_step, smp_if.out_valid}, 3'b000);
      if (ena) begin
        if (pv_valid && !pv_ready && !pv_abort) begin
          chk("hold_valid", smp_if.out_valid, 1'b1);
          chk("hold_data", smp_if.out_data, pv_data);
        end
        if (smp_if.out_valid && smp_if.out_ready && !abort) begin
          hs_q.push_back(rel);
          hsd_q.push_back(smp_if.out_data);
          chk("sample_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) chk("sample_data", smp_if.out_data, exp_q.pop_front());
        end
        pv_valid = smp_if.out_valid;
        pv_ready = smp_if.out_ready;
        pv_abort = abort;
        pv_data  = smp_if.out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] s, input logic [7:0] c);
    logic [7:0] v;
    load_q.delete(); step_q.delete(); hs_q.delete(); done_q.delete();
    hsd_q.delete(); exp_q.delete();
    busy_n = 0;
    if (c != 0 && s != 0) begin
      v = s;
      for (int i = 0; i < int'(c); i++) begin
        exp_q.push_back(v);
        v = lfsr_next(v);
      end
    end
    seed = s; count = c; start = 1'b1;
    tick();
    base = edge_cnt - 1;
    start = 1'b0;
  endtask

  task automatic at_edge(input int k);
    while ((edge_cnt - base) < k + 1) tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 1'b0);
    repeat (2) tick();
  endtask

  int w[$];

  initial begin
    smp_if.out_ready = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", smp_if.out_valid, 0);
    chk("rst_data", smp_if.out_data, 0);
    chk("rst_seed", lfsr_seed, 0);
    chk("rst_err", err_lockup, 0);
    chk("rst_strobes", {lfsr_load, lfsr_step, done}, 0);
    #11 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // nominal run
    do_start(8'h01, 8'd3);
    wait_idle("nom");
    w = {1};       chk_q("nom_load", load_q, w);
    w = {4, 7};    chk_q("nom_step", step_q, w);
    w = {3, 6, 9}; chk_q("nom_hs", hs_q, w);
    chk("nom_d0", hsd_q[0], 8'h01);
    chk("nom_d1", hsd_q[1], 8'h02);
    chk("nom_d2", hsd_q[2], 8'h04);
    w = {10};      chk_q("nom_done", done_q, w);
    chk("nom_busy_cycles", busy_n, 10);

    // backpressure during cycles 3-7
    do_start(8'h01, 8'd3);
    at_edge(2); smp_if.out_ready = 1'b0;
    at_edge(4); #2;
    chk("bp_valid_c5", smp_if.out_valid, 1'b1);
    chk("bp_data_c5", smp_if.out_data, 8'h01);
    at_edge(7); smp_if.out_ready = 1'b1;
    wait_idle("bp");
    w = {8, 11, 14}; chk_q("bp_hs", hs_q, w);
    chk("bp_d0", hsd_q[0], 8'h01);
    chk("bp_d2", hsd_q[2], 8'h04);
    w = {15};        chk_q("bp_done", done_q, w);

    // lockup seed
    do_start(8'h00, 8'd5);
    wait_idle("lock");
    chk("lock_err", err_lockup, 1'b1);
    chk("lock_loads", load_q.size(), 0);
    w = {1}; chk_q("lock_done", done_q, w);
    chk("lock_busy_cycles", busy_n, 1);

    // count zero keeps the sticky error
    do_start(8'h3C, 8'd0);
    wait_idle("cnt0");
    chk("cnt0_err", err_lockup, 1'b1);
    chk("cnt0_loads", load_q.size(), 0);
    chk("cnt0_samples", hs_q.size(), 0);
    w = {1}; chk_q("cnt0_done", done_q, w);

    // a good seed clears the error
    do_start(8'hA5, 8'd1);
    chk("clr_err", err_lockup, 1'b0);
    wait_idle("clr");
    w = {3}; chk_q("clr_hs", hs_q, w);
    chk("clr_d0", hsd_q[0], 8'hA5);
    w = {4}; chk_q("clr_done", done_q, w);

    // abort during the second EMIT; a start while busy is ignored
    do_start(8'h01, 8'd10);
    at_edge(1); start = 1'b1; seed = 8'h77; count = 8'd2;
    at_edge(2); start = 1'b0;
    at_edge(5); abort = 1'b1;
    at_edge(6); abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", smp_if.out_valid, 1'b0);
    wait_idle("abort");
    w = {1}; chk_q("abort_load", load_q, w);
    w = {3}; chk_q("abort_hs", hs_q, w);
    chk("abort_d0", hsd_q[0], 8'h01);
    chk("abort_done", done_q.size(), 0);

    // freeze for cycles 4-7 while in STEP
    do_start(8'h01, 8'd3);
    at_edge(3); ena = 1'b0;
    #2 chk("frz_step_gated", lfsr_step, 1'b0);
    at_edge(7); ena = 1'b1;
    wait_idle("frz");
    w = {8, 11};     chk_q("frz_step", step_q, w);
    w = {3, 10, 13}; chk_q("frz_hs", hs_q, w);
    chk("frz_d1", hsd_q[1], 8'h02);
    chk("frz_d2", hsd_q[2], 8'h04);
    w = {14};        chk_q("frz_done", done_q, w);

    // asynchronous reset mid-EMIT
    do_start(8'h01, 8'd3);
    at_edge(2); smp_if.out_ready = 1'b0;
    at_edge(3); #2;
    chk("ar_pre_valid", smp_if.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", smp_if.out_valid, 1'b0);
    chk("ar_data", smp_if.out_data, 0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_seed", lfsr_seed, 0);
    chk("ar_strobes", {lfsr_load, lfsr_step, done, err_lockup}, 0);
    #10 rst_n = 1'b1;
    smp_if.out_ready = 1'b1;
    tick();
    chk("ar_post_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
